corr_window_engine: RTL



---
 rtl/corr_window_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/corr_window_engine.sv
// corr_window_engine: streams a TPL_W x TPL_H window of the frame store and
// the template ROM, multiplies pixel pairs and accumulates a saturating
// 32-bit correlation. The result is returned with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for iStart; origin latched on accept
// RUN   | one window offset issued per cycle, row-major
// DRAIN | read/multiply/accumulate pipeline emptying
// DONE  | result valid, oCorrFinished pulsed for one cycle
module corr_window_engine #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int TPL_W   = 16,
  parameter int TPL_H   = 16,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 19,
  parameter int TADDR_W = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [12:0]        iX,
  input  logic [12:0]        iY,
  output logic               oBusy,
  output logic [ADDR_W-1:0]  oFrameAddr,
  input  logic [PIX_W-1:0]   iFrameData,
  output logic [TADDR_W-1:0] oTplAddr,
  input  logic [PIX_W-1:0]   iTplData,
  output logic               oCorrFinished,
  output logic [31:0]        oCurrentCorr
);

  localparam int N = TPL_W * TPL_H;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  // window walk: px/py track the current pixel, row_base_q = py * H_RES
  logic [31:0] k_q, col_q, x_q, px_q, py_q, row_base_q;
  logic [1:0]  drain_q;

  // per-stage tags: offset issued and inside the frame
  logic ok1_q, ok2_q, ok3_q;

  logic [2*PIX_W-1:0] prod_q, prod_d;
  logic [31:0]        acc_q, acc_d, corr_q;
  logic [32:0]        sum_w;
  logic [ADDR_W-1:0]  faddr_q;
  logic [TADDR_W-1:0] taddr_q;
  logic               start_w, in_range_w;

  assign start_w    = (state_q == S_IDLE) && iStart;
  assign in_range_w = (px_q < H_RES) && (py_q < V_RES);
  assign prod_d     = (2*PIX_W)'(iFrameData) * (2*PIX_W)'(iTplData);
  assign sum_w      = {1'b0, acc_q} + 33'(prod_q);

  // saturating accumulate of the product currently leaving the multiplier
  always_comb begin
    acc_d = acc_q;
    if (ok3_q) acc_d = sum_w[32] ? 32'hFFFF_FFFF : sum_w[31:0];
  end

  // state register
  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_RUN;
      S_RUN:   if (k_q == N - 1) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    oBusy         = (state_q != S_IDLE);
    oCorrFinished = (state_q == S_DONE);
  end

  // address walk, read pipeline, multiply and accumulate
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      k_q        <= '0;
      col_q      <= '0;
      x_q        <= '0;
      px_q       <= '0;
      py_q       <= '0;
      row_base_q <= '0;
      drain_q    <= '0;
      ok1_q      <= 1'b0;
      ok2_q      <= 1'b0;
      ok3_q      <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      corr_q     <= '0;
      faddr_q    <= '0;
      taddr_q    <= '0;
    end else begin
      ok1_q  <= 1'b0;
      ok2_q  <= ok1_q;
      ok3_q  <= ok2_q;
      prod_q <= ok2_q ? prod_d : '0;
      acc_q  <= acc_d;
      if (start_w) begin
        x_q        <= 32'(iX);
        px_q       <= 32'(iX);
        py_q       <= 32'(iY);
        // constant-coefficient scale, evaluated once per run
        row_base_q <= 32'(iY) * H_RES;
        col_q      <= '0;
        k_q        <= '0;
        acc_q      <= '0;
      end
      if (state_q == S_RUN) begin
        taddr_q <= TADDR_W'(k_q);
        // clipped offsets leave the frame address where it was
        if (in_range_w) faddr_q <= ADDR_W'(row_base_q + px_q);
        ok1_q   <= in_range_w;
        k_q     <= k_q + 32'd1;
        drain_q <= 2'd2;
        if (col_q == TPL_W - 1) begin
          col_q      <= '0;
          px_q       <= x_q;
          py_q       <= py_q + 32'd1;
          row_base_q <= row_base_q + 32'(H_RES);
        end else begin
          col_q <= col_q + 32'd1;
          px_q  <= px_q + 32'd1;
        end
      end
      if (state_q == S_DRAIN) begin
        drain_q <= drain_q - 2'd1;
        if (drain_q == 2'd0) corr_q <= acc_d;
      end
    end
  end

  assign oFrameAddr   = faddr_q;
  assign oTplAddr     = taddr_q;
  assign oCurrentCorr = corr_q;

endmodule
